debug_pram_arbiter: RTL and testbench

Shares the single-port program RAM between the CPU memory port and the on-chip debug coprocessor. It sits between the debug coprocessor's PRAM read/write strobes, the CPU's request/grant port and the RAM macro. It captures the coprocessor's single-cycle strobes into pending slots and arbitrates them against CPU requests. It routes synchronous read data back to whichever side issued the read. While the coprocessor holds the CPU in reset, the RAM belongs exclusively to the debugger.

---
 rtl/debug_pram_arbiter.sv | 159 +++++++++++++++
 tb/tb_debug_pram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_pram_arbiter.sv
// debug_pram_arbiter
// Shares the single-port program RAM between the CPU memory port and the
// on-chip debug coprocessor. Coprocessor strobes are captured into one write
// slot and one read slot. The slots outrank the CPU, and the write slot is
// served before the read slot. Read data is routed back to whichever side
// issued the read.
module debug_pram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    // debug coprocessor side
    input  logic                    ocd_lock_in,
    input  logic                    ocd_read_enable_in,
    input  logic [ADDR_WIDTH-1:0]   ocd_read_addr_in,
    input  logic                    ocd_write_enable_in,
    input  logic [ADDR_WIDTH-3:0]   ocd_write_addr_in,
    input  logic [DATA_WIDTH-1:0]   ocd_write_data_in,
    output logic                    ocd_read_enable_out,
    output logic [DATA_WIDTH-1:0]   ocd_read_data_out,
    // CPU side
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-3:0]   cpu_addr,
    input  logic [3:0]              cpu_be,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    // RAM macro side
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [3:0]              mem_be,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int WA = ADDR_WIDTH - 2;

    // pending coprocessor requests
    logic                  wr_pend_r;
    logic [WA-1:0]         wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic                  rd_pend_r;
    logic [WA-1:0]         rd_addr_r;

    // read return tracking
    logic                  rd_owner_ocd_r;
    logic                  rd_owner_cpu_r;
    logic                  ocd_rd_en_r;
    logic [DATA_WIDTH-1:0] ocd_rd_data_r;

    // arbitration decisions for the current cycle
    logic                  issue_wr_s;
    logic                  issue_rd_s;
    logic                  gnt_s;

    // The byte-offset bits of the coprocessor read address carry no meaning.
    logic                  unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^ocd_read_addr_in[1:0];

    // Fixed-priority arbitration from the registered slots: write, read, then CPU.
    always_comb begin
        issue_wr_s = 1'b0;
        issue_rd_s = 1'b0;
        gnt_s      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_addr   = {WA{1'b0}};
        mem_wdata  = {DATA_WIDTH{1'b0}};
        if (wr_pend_r) begin
            issue_wr_s = 1'b1;
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_be     = 4'hF;
            mem_addr   = wr_addr_r;
            mem_wdata  = wr_data_r;
        end else if (rd_pend_r) begin
            issue_rd_s = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = rd_addr_r;
        end else if (cpu_req && !ocd_lock_in) begin
            gnt_s      = 1'b1;
            mem_en     = 1'b1;
            mem_we     = cpu_we;
            mem_be     = cpu_we ? cpu_be : 4'h0;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
        end else begin
            gnt_s      = 1'b0;
        end
    end

    // Write slot: capture a strobe when empty; a strobe while pending is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pend_r <= 1'b0;
            wr_addr_r <= {WA{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else if (wr_pend_r) begin
            if (issue_wr_s) begin
                wr_pend_r <= 1'b0;
            end
        end else if (ocd_write_enable_in) begin
            wr_pend_r <= 1'b1;
            wr_addr_r <= ocd_write_addr_in;
            wr_data_r <= ocd_write_data_in;
        end
    end

    // Read slot: waits behind a pending write so that a read-back sees the new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_r <= 1'b0;
            rd_addr_r <= {WA{1'b0}};
        end else if (rd_pend_r) begin
            if (issue_rd_s) begin
                rd_pend_r <= 1'b0;
            end
        end else if (ocd_read_enable_in) begin
            rd_pend_r <= 1'b1;
            rd_addr_r <= ocd_read_addr_in[ADDR_WIDTH-1:2];
        end
    end

    // Remember who issued the read whose data appears on mem_rdata next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_ocd_r <= 1'b0;
            rd_owner_cpu_r <= 1'b0;
        end else begin
            rd_owner_ocd_r <= issue_rd_s;
            rd_owner_cpu_r <= gnt_s && !cpu_we;
        end
    end

    // Register the coprocessor's read data and pulse its valid one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocd_rd_en_r   <= 1'b0;
            ocd_rd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            ocd_rd_en_r <= rd_owner_ocd_r;
            if (rd_owner_ocd_r) begin
                ocd_rd_data_r <= mem_rdata;
            end
        end
    end

    assign cpu_gnt             = gnt_s;
    assign cpu_rvalid          = rd_owner_cpu_r;
    assign cpu_rdata           = mem_rdata;
    assign ocd_read_enable_out = ocd_rd_en_r;
    assign ocd_read_data_out   = ocd_rd_data_r;

endmodule

// File: tb/tb_debug_pram_arbiter.sv
// tb_debug_pram_arbiter
// Directed stimulus with a scoreboard. The stimulus pushes the expected read
// data for each read, and a monitor pops and compares it whenever
// ocd_read_enable_out or cpu_rvalid is high. A behavioural RAM initialised to
// 0xC0DE0000 | word_address stands in for the RAM macro.
module tb_debug_pram_arbiter;

    localparam int AW = 16;
    localparam int WA = AW - 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ocd_lock_in;
    logic          ocd_read_enable_in;
    logic [AW-1:0] ocd_read_addr_in;
    logic          ocd_write_enable_in;
    logic [WA-1:0] ocd_write_addr_in;
    logic [31:0]   ocd_write_data_in;
    logic          ocd_read_enable_out;
    logic [31:0]   ocd_read_data_out;
    logic          cpu_req;
    logic          cpu_we;
    logic [WA-1:0] cpu_addr;
    logic [3:0]    cpu_be;
    logic [31:0]   cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [WA-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0]   ram [0:(1<<WA)-1];
    logic [31:0]   exp_ocd_q [$];
    logic [31:0]   exp_cpu_q [$];
    int            n_vec = 0;
    int            n_fail = 0;
    int            ocd_pulses = 0;

    debug_pram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .ocd_lock_in(ocd_lock_in),
        .ocd_read_enable_in(ocd_read_enable_in), .ocd_read_addr_in(ocd_read_addr_in),
        .ocd_write_enable_in(ocd_write_enable_in), .ocd_write_addr_in(ocd_write_addr_in),
        .ocd_write_data_in(ocd_write_data_in),
        .ocd_read_enable_out(ocd_read_enable_out), .ocd_read_data_out(ocd_read_data_out),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Load the RAM with its recognisable pattern.
    initial begin
        for (int i = 0; i < (1 << WA); i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    end

    // Synchronous single-port RAM with byte lanes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: compare every read return against the scoreboard queues.
    always @(negedge clk) begin
        if (ocd_read_enable_out) begin
            ocd_pulses++;
            if (exp_ocd_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL ocd_ret_unexpected: got data %h, expected no return", ocd_read_data_out);
            end else begin
                chk("ocd_ret_data", ocd_read_data_out, exp_ocd_q.pop_front());
            end
        end
        if (cpu_rvalid) begin
            if (exp_cpu_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL cpu_ret_unexpected: got data %h, expected no return", cpu_rdata);
            end else begin
                chk("cpu_ret_data", cpu_rdata, exp_cpu_q.pop_front());
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int stalls;
        int lock_gnts;
        int base;
        logic g;
        reset = 1'b1;
        ocd_lock_in = 1'b0;
        ocd_read_enable_in = 1'b0;
        ocd_read_addr_in = 16'h0;
        ocd_write_enable_in = 1'b0;
        ocd_write_addr_in = 14'h0;
        ocd_write_data_in = 32'h0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 14'h0;
        cpu_be = 4'h0;
        cpu_wdata = 32'h0;

        // reset state
        mid();
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_ocd_ren", 32'(ocd_read_enable_out), 32'h0);
        chk("rst_ocd_rdata", ocd_read_data_out, 32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // simultaneous read and write strobes on the same word
        ocd_read_enable_in = 1'b1;
        ocd_read_addr_in = 16'h0040;
        ocd_write_enable_in = 1'b1;
        ocd_write_addr_in = 14'h010;
        ocd_write_data_in = 32'hDEADBEEF;
        exp_ocd_q.push_back(32'hDEADBEEF);
        mid();
        chk("simul_T_idle", 32'(mem_en), 32'h0);
        next_cycle();
        ocd_read_enable_in = 1'b0;
        ocd_write_enable_in = 1'b0;
        mid();
        chk("simul_T1_we", {31'h0, mem_en & mem_we}, 32'h1);
        chk("simul_T1_addr", 32'(mem_addr), 32'h010);
        chk("simul_T1_be", 32'(mem_be), 32'hF);
        chk("simul_T1_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        mid();
        chk("simul_T2_rd", {30'h0, mem_en, mem_we}, 32'h2);
        chk("simul_T2_addr", 32'(mem_addr), 32'h010);
        chk("simul_T2_be", 32'(mem_be), 32'h0);
        next_cycle();
        mid();
        chk("simul_T3_noret", 32'(ocd_read_enable_out), 32'h0);
        next_cycle();
        mid();
        chk("simul_T4_ret", 32'(ocd_read_enable_out), 32'h1);

        // OCD write while the CPU streams reads
        next_cycle();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h020;
        ocd_write_enable_in = 1'b1;
        ocd_write_addr_in = 14'h010;
        ocd_write_data_in = 32'hDEADBEEF;
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            mid();
            g = cpu_gnt;
            if (c == 1) begin
                chk("stream_wr_we", {31'h0, mem_en & mem_we}, 32'h1);
                chk("stream_wr_be", 32'(mem_be), 32'hF);
                chk("stream_wr_addr", 32'(mem_addr), 32'h010);
            end
            if (g) exp_cpu_q.push_back(32'hC0DE_0000 | 32'(cpu_addr));
            else stalls++;
            next_cycle();
            ocd_write_enable_in = 1'b0;
            if (g) cpu_addr = cpu_addr + 14'h1;
        end
        cpu_req = 1'b0;
        chk("stream_stalls", 32'(stalls), 32'h1);
        next_cycle();

        // lock: in-flight read still returns; no grant while locked
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h030;
        mid();
        chk("lock_pre_gnt", 32'(cpu_gnt), 32'h1);
        exp_cpu_q.push_back(32'hC0DE0030);
        next_cycle();
        ocd_lock_in = 1'b1;
        cpu_addr = 14'h031;
        lock_gnts = 0;
        for (int c = 0; c < 4; c++) begin
            mid();
            if (cpu_gnt) lock_gnts++;
            if (c == 0) chk("lock_inflight_rvalid", 32'(cpu_rvalid), 32'h1);
            next_cycle();
        end
        chk("lock_gnts", 32'(lock_gnts), 32'h0);
        ocd_lock_in = 1'b0;
        mid();
        chk("unlock_gnt", 32'(cpu_gnt), 32'h1);
        exp_cpu_q.push_back(32'hC0DE0031);
        next_cycle();
        cpu_req = 1'b0;

        // second read strobe while rd_pend is held behind a write is dropped
        next_cycle();
        ocd_write_enable_in = 1'b1;
        ocd_write_addr_in = 14'h050;
        ocd_write_data_in = 32'h0BADCAFE;
        ocd_read_enable_in = 1'b1;
        ocd_read_addr_in = 16'h0180;
        exp_ocd_q.push_back(32'hC0DE0060);
        base = ocd_pulses;
        next_cycle();
        ocd_write_enable_in = 1'b0;
        ocd_read_addr_in = 16'h01C0;
        next_cycle();
        ocd_read_enable_in = 1'b0;
        repeat (6) next_cycle();
        chk("drop_pulse_count", 32'(ocd_pulses - base), 32'h1);

        // CPU partial write, then read-back
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 14'h080;
        cpu_be = 4'b0011;
        cpu_wdata = 32'h5555AAAA;
        mid();
        chk("cpuwr_gnt", 32'(cpu_gnt), 32'h1);
        chk("cpuwr_we", 32'(mem_we), 32'h1);
        chk("cpuwr_be", 32'(mem_be), 32'h3);
        chk("cpuwr_wdata", mem_wdata, 32'h5555AAAA);
        next_cycle();
        cpu_we = 1'b0;
        cpu_be = 4'hF;
        mid();
        chk("cpurd_be", 32'(mem_be), 32'h0);
        exp_cpu_q.push_back(32'hC0DEAAAA);
        next_cycle();
        cpu_req = 1'b0;
        mid();
        chk("cpurd_rvalid", 32'(cpu_rvalid), 32'h1);

        // reset pulse with a CPU read in flight
        next_cycle();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 14'h005;
        mid();
        chk("rstcpu_gnt", 32'(cpu_gnt), 32'h1);
        #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        mid();
        chk("rstmid_mem_en", 32'(mem_en), 32'h0);
        chk("rstmid_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rstmid_ocd_ren", 32'(ocd_read_enable_out), 32'h0);
        chk("rstmid_ocd_rdata", ocd_read_data_out, 32'h0);
        next_cycle();
        reset = 1'b0;

        // reset pulse with an OCD read in flight
        next_cycle();
        ocd_read_enable_in = 1'b1;
        ocd_read_addr_in = 16'h0200;
        next_cycle();
        ocd_read_enable_in = 1'b0;
        mid();
        chk("rstocd_issue", {30'h0, mem_en, mem_we}, 32'h2);
        #1;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        repeat (6) next_cycle();

        chk("ocd_q_empty", 32'(exp_ocd_q.size()), 32'h0);
        chk("cpu_q_empty", 32'(exp_cpu_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
